// File: rtl/mem_pkg.sv
// Shared types and constants for the memory requester.
package mem_pkg;

    localparam int unsigned WORD_W            = 32;
    localparam int unsigned DEFAULT_ADDR_STEP = 4;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        REQ,
        DRAIN,
        FINISH
    } req_state_t;

endpackage

// File: rtl/req_watchdog.sv
// Request timeout counter: counts enabled cycles and flags when the limit is reached.
module req_watchdog #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CW-1:0] count_q;

    assign expired = (count_q == CW'(TIMEOUT - 1));

    // Count waiting cycles; saturate at the limit so the flag stays up until cleared.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable && !expired) begin
            count_q <= count_q + CW'(1);
        end
    end

endmodule

// File: rtl/mem_requester.sv
// Burst initiator for the single-port word memory: one outstanding request at a time.
module mem_requester
    import mem_pkg::*;
#(
    parameter int unsigned ADDR_STEP = DEFAULT_ADDR_STEP,
    parameter int unsigned LEN_W     = 16,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [31:0]       cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              cmd_done,
    output logic              err,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [WORD_W-1:0] wdata,
    output logic              rdata_valid,
    input  logic              rdata_ready,
    output logic [WORD_W-1:0] rdata,
    output logic [31:0]       mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              mem_w_enable,
    output logic              mem_r_enable,
    input  logic              mem_done,
    input  logic [WORD_W-1:0] mem_rdata
);

    req_state_t       state_q;
    logic [LEN_W-1:0] remaining_q;
    logic             is_write_q;

    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    // The watchdog only runs while a request waits; completion or leaving REQ rearms it.
    assign wd_clear  = (state_q != REQ) || mem_done;
    assign wd_enable = (state_q == REQ) && !mem_done;

    req_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // Burst sequencer; every handshake and strobe output is registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            remaining_q  <= '0;
            is_write_q   <= 1'b0;
            cmd_ready    <= 1'b1;
            cmd_done     <= 1'b0;
            err          <= 1'b0;
            wdata_ready  <= 1'b0;
            rdata_valid  <= 1'b0;
            rdata        <= '0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_w_enable <= 1'b0;
            mem_r_enable <= 1'b0;
        end else begin
            cmd_done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        is_write_q  <= cmd_write;
                        mem_addr    <= cmd_addr;
                        remaining_q <= cmd_len;
                        err         <= 1'b0;
                        cmd_ready   <= 1'b0;
                        if (cmd_len == '0) begin
                            state_q  <= FINISH;
                            cmd_done <= 1'b1;
                        end else if (cmd_write) begin
                            state_q     <= FETCH;
                            wdata_ready <= 1'b1;
                        end else begin
                            state_q      <= REQ;
                            mem_r_enable <= 1'b1;
                        end
                    end
                end
                FETCH: begin
                    if (wdata_valid) begin
                        mem_wdata    <= wdata;
                        wdata_ready  <= 1'b0;
                        mem_w_enable <= 1'b1;
                        state_q      <= REQ;
                    end
                end
                REQ: begin
                    // A completion in the expiry cycle still counts as a completion.
                    if (mem_done) begin
                        mem_w_enable <= 1'b0;
                        mem_r_enable <= 1'b0;
                        remaining_q  <= remaining_q - LEN_W'(1);
                        mem_addr     <= mem_addr + 32'(ADDR_STEP);
                        if (is_write_q) begin
                            if (remaining_q == LEN_W'(1)) begin
                                state_q  <= FINISH;
                                cmd_done <= 1'b1;
                            end else begin
                                state_q     <= FETCH;
                                wdata_ready <= 1'b1;
                            end
                        end else begin
                            rdata       <= mem_rdata;
                            rdata_valid <= 1'b1;
                            state_q     <= DRAIN;
                        end
                    end else if (wd_expired) begin
                        err          <= 1'b1;
                        mem_w_enable <= 1'b0;
                        mem_r_enable <= 1'b0;
                        state_q      <= FINISH;
                        cmd_done     <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (rdata_ready) begin
                        rdata_valid <= 1'b0;
                        if (remaining_q == '0) begin
                            state_q  <= FINISH;
                            cmd_done <= 1'b1;
                        end else begin
                            state_q      <= REQ;
                            mem_r_enable <= 1'b1;
                        end
                    end
                end
                FINISH: begin
                    state_q   <= IDLE;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_requester.sv
// Directed, table-driven bench for mem_requester with a small behavioural memory.
module tb_mem_requester;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [15:0] cmd_len = '0;
    logic        cmd_done;
    logic        err;
    logic        wdata_valid = 1'b0;
    logic        wdata_ready;
    logic [31:0] wdata = '0;
    logic        rdata_valid;
    logic        rdata_ready = 1'b0;
    logic [31:0] rdata;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_w_enable;
    logic        mem_r_enable;
    logic        mem_done = 1'b0;
    logic [31:0] mem_rdata = '0;

    int checks = 0;
    int errors = 0;

    mem_requester #(
        .ADDR_STEP (4),
        .LEN_W     (16),
        .TIMEOUT   (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_write    (cmd_write),
        .cmd_addr     (cmd_addr),
        .cmd_len      (cmd_len),
        .cmd_done     (cmd_done),
        .err          (err),
        .wdata_valid  (wdata_valid),
        .wdata_ready  (wdata_ready),
        .wdata        (wdata),
        .rdata_valid  (rdata_valid),
        .rdata_ready  (rdata_ready),
        .rdata        (rdata),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_w_enable (mem_w_enable),
        .mem_r_enable (mem_r_enable),
        .mem_done     (mem_done),
        .mem_rdata    (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global timeout");
        $fatal(1, "simulation time limit");
    end

    // Memory model: done in the second cycle of a request, read data = addr ^ A5A5A5A5.
    localparam int MEM_LAT = 2;
    logic        mem_hang = 1'b0;
    int          lat_cnt = 0;
    logic [31:0] wr_addr_q [$];
    logic [31:0] wr_data_q [$];

    always @(negedge clk) begin
        if (mem_w_enable || mem_r_enable) begin
            lat_cnt = lat_cnt + 1;
            if (!mem_hang && lat_cnt == MEM_LAT) begin
                mem_done  = 1'b1;
                mem_rdata = mem_addr ^ 32'hA5A5A5A5;
                if (mem_w_enable) begin
                    wr_addr_q.push_back(mem_addr);
                    wr_data_q.push_back(mem_wdata);
                end
            end else begin
                mem_done  = 1'b0;
                mem_rdata = '0;
            end
        end else begin
            lat_cnt  = 0;
            mem_done = 1'b0;
        end
    end

    // Protocol monitor: request log, read log, done pulses and invariant violations.
    logic [31:0] req_q [$];
    logic [31:0] rd_q [$];
    int          done_cnt = 0;
    int          viol = 0;
    logic        prev_en = 1'b0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_rdata = '0;
    logic [31:0] prev_addr = '0;

    always @(negedge clk) begin
        if ((mem_r_enable || mem_w_enable) && !prev_en) req_q.push_back(mem_addr);
        if ((mem_r_enable || mem_w_enable) && prev_en && mem_addr != prev_addr) viol++;
        if (mem_r_enable && mem_w_enable) viol++;
        if ((mem_r_enable || mem_w_enable) && (wdata_ready || rdata_valid)) viol++;
        if (prev_stall && rdata_valid && rdata != prev_rdata) viol++;
        if (cmd_done) done_cnt++;
        if (rdata_valid && rdata_ready) rd_q.push_back(rdata);
        prev_en    = mem_r_enable || mem_w_enable;
        prev_addr  = mem_addr;
        prev_stall = rdata_valid && !rdata_ready;
        prev_rdata = rdata;
    end

    typedef struct {
        logic        write;
        logic [31:0] addr;
        logic [15:0] len;
        int          stall;
        int          gap;
        logic [31:0] wd0;
        logic [31:0] wd1;
        int          exp_reqs;
        logic [31:0] exp_first;
        logic [31:0] exp_last;
        logic [31:0] exp_d_first;
        logic [31:0] exp_d_last;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue_cmd(input logic w, input logic [31:0] a, input logic [15:0] l);
        int cyc = 0;
        while (!cmd_ready && cyc < 100) begin
            tick();
            cyc++;
        end
        check("cmd_ready wait", 32'(cyc < 100), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_len   = l;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic run_burst(input int idx, input vec_t v);
        int widx = 0;
        int gap_cnt = 0;
        int stall_cnt = 0;
        int cyc = 0;
        int d0 = done_cnt;
        req_q.delete();
        rd_q.delete();
        wr_addr_q.delete();
        wr_data_q.delete();
        rdata_ready = (v.stall == 0);
        issue_cmd(v.write, v.addr, v.len);
        while (done_cnt == d0 && cyc < 400) begin
            if (wdata_valid) begin
                wdata_valid = 1'b0;
            end else if (wdata_ready) begin
                if (gap_cnt >= v.gap) begin
                    wdata_valid = 1'b1;
                    wdata = (widx == 0) ? v.wd0 : v.wd1;
                    widx++;
                    gap_cnt = 0;
                end else begin
                    gap_cnt++;
                end
            end
            if (v.stall != 0) begin
                if (rdata_ready) begin
                    rdata_ready = 1'b0;
                end else if (rdata_valid) begin
                    if (stall_cnt >= v.stall) begin
                        rdata_ready = 1'b1;
                        stall_cnt = 0;
                    end else begin
                        stall_cnt++;
                    end
                end
            end
            tick();
            cyc++;
        end
        wdata_valid = 1'b0;
        rdata_ready = 1'b0;
        tick();
        tick();
        check($sformatf("v%0d done wait", idx), 32'(cyc < 400), 32'd1);
        check($sformatf("v%0d cmd_done count", idx), 32'(done_cnt - d0), 32'd1);
        check($sformatf("v%0d requests", idx), 32'(req_q.size()), 32'(v.exp_reqs));
        check($sformatf("v%0d err", idx), 32'(err), 32'd0);
        if (req_q.size() > 0) begin
            check($sformatf("v%0d first addr", idx), req_q[0], v.exp_first);
            check($sformatf("v%0d last addr", idx), req_q[req_q.size()-1], v.exp_last);
        end
        if (v.write) begin
            check($sformatf("v%0d writes", idx), 32'(wr_data_q.size()), 32'(v.len));
            if (wr_data_q.size() > 0) begin
                check($sformatf("v%0d wr first addr", idx), wr_addr_q[0], v.exp_first);
                check($sformatf("v%0d wr first data", idx), wr_data_q[0], v.exp_d_first);
                check($sformatf("v%0d wr last addr", idx), wr_addr_q[wr_addr_q.size()-1],
                      v.exp_last);
                check($sformatf("v%0d wr last data", idx), wr_data_q[wr_data_q.size()-1],
                      v.exp_d_last);
            end
        end else begin
            check($sformatf("v%0d reads", idx), 32'(rd_q.size()), 32'(v.len));
            if (rd_q.size() > 0) begin
                check($sformatf("v%0d rdata first", idx), rd_q[0], v.exp_d_first);
                check($sformatf("v%0d rdata last", idx), rd_q[rd_q.size()-1], v.exp_d_last);
            end
        end
    endtask

    initial begin
        vec_t vecs [6];
        int   cnt;
        int   d0;

        vecs[0] = '{write: 1'b0, addr: 32'h0000_0100, len: 16'd3, stall: 0, gap: 0,
                    wd0: 32'h0, wd1: 32'h0, exp_reqs: 3,
                    exp_first: 32'h0000_0100, exp_last: 32'h0000_0108,
                    exp_d_first: 32'hA5A5_A4A5, exp_d_last: 32'hA5A5_A4AD};
        vecs[1] = '{write: 1'b1, addr: 32'h0000_0200, len: 16'd2, stall: 0, gap: 3,
                    wd0: 32'hDEAD_BEEF, wd1: 32'h1234_5678, exp_reqs: 2,
                    exp_first: 32'h0000_0200, exp_last: 32'h0000_0204,
                    exp_d_first: 32'hDEAD_BEEF, exp_d_last: 32'h1234_5678};
        vecs[2] = '{write: 1'b0, addr: 32'h0000_0500, len: 16'd2, stall: 5, gap: 0,
                    wd0: 32'h0, wd1: 32'h0, exp_reqs: 2,
                    exp_first: 32'h0000_0500, exp_last: 32'h0000_0504,
                    exp_d_first: 32'hA5A5_A0A5, exp_d_last: 32'hA5A5_A0A1};
        vecs[3] = '{write: 1'b0, addr: 32'hFFFF_FFFC, len: 16'd2, stall: 0, gap: 0,
                    wd0: 32'h0, wd1: 32'h0, exp_reqs: 2,
                    exp_first: 32'hFFFF_FFFC, exp_last: 32'h0000_0000,
                    exp_d_first: 32'h5A5A_5A59, exp_d_last: 32'hA5A5_A5A5};
        vecs[4] = '{write: 1'b1, addr: 32'hFFFF_FFFC, len: 16'd2, stall: 0, gap: 0,
                    wd0: 32'h0BAD_F00D, wd1: 32'hCAFE_F00D, exp_reqs: 2,
                    exp_first: 32'hFFFF_FFFC, exp_last: 32'h0000_0000,
                    exp_d_first: 32'h0BAD_F00D, exp_d_last: 32'hCAFE_F00D};
        vecs[5] = '{write: 1'b1, addr: 32'h0000_0600, len: 16'd1, stall: 0, gap: 1,
                    wd0: 32'h1111_1111, wd1: 32'h1111_1111, exp_reqs: 1,
                    exp_first: 32'h0000_0600, exp_last: 32'h0000_0600,
                    exp_d_first: 32'h1111_1111, exp_d_last: 32'h1111_1111};

        // Reset values.
        tick();
        tick();
        check("rst cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst cmd_done", 32'(cmd_done), 32'd0);
        check("rst err", 32'(err), 32'd0);
        check("rst enables", 32'({mem_w_enable, mem_r_enable}), 32'd0);
        check("rst rdata_valid", 32'(rdata_valid), 32'd0);
        check("rst wdata_ready", 32'(wdata_ready), 32'd0);
        check("rst mem_addr", mem_addr, 32'h0);
        check("rst rdata", rdata, 32'h0);
        reset = 1'b0;
        tick();

        // Single read word, cycle by cycle.
        rdata_ready = 1'b1;
        issue_cmd(1'b0, 32'h0000_0700, 16'd1);
        check("rd1 c1 r_enable", 32'(mem_r_enable), 32'd1);
        check("rd1 c1 cmd_ready", 32'(cmd_ready), 32'd0);
        check("rd1 c1 mem_addr", mem_addr, 32'h0000_0700);
        tick();
        check("rd1 c2 r_enable", 32'(mem_r_enable), 32'd1);
        check("rd1 c2 rdata_valid", 32'(rdata_valid), 32'd0);
        tick();
        check("rd1 c3 rdata_valid", 32'(rdata_valid), 32'd1);
        check("rd1 c3 r_enable", 32'(mem_r_enable), 32'd0);
        check("rd1 c3 rdata", rdata, 32'hA5A5_A2A5);
        tick();
        check("rd1 c4 cmd_done", 32'(cmd_done), 32'd1);
        check("rd1 c4 cmd_ready", 32'(cmd_ready), 32'd0);
        tick();
        check("rd1 c5 cmd_ready", 32'(cmd_ready), 32'd1);
        check("rd1 c5 cmd_done", 32'(cmd_done), 32'd0);
        rdata_ready = 1'b0;

        // Zero-length command.
        req_q.delete();
        issue_cmd(1'b1, 32'h0000_0800, 16'd0);
        check("zl cmd_done", 32'(cmd_done), 32'd1);
        check("zl wdata_ready", 32'(wdata_ready), 32'd0);
        tick();
        check("zl cmd_ready", 32'(cmd_ready), 32'd1);
        check("zl cmd_done low", 32'(cmd_done), 32'd0);
        tick();
        check("zl requests", 32'(req_q.size()), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_burst(i, vecs[i]);
        end

        // Timeout: memory never completes.
        mem_hang = 1'b1;
        issue_cmd(1'b0, 32'h0000_0300, 16'd3);
        cnt = 0;
        while (mem_r_enable && cnt < 50) begin
            cnt++;
            tick();
        end
        check("to enable cycles", 32'(cnt), 32'd8);
        check("to cmd_done", 32'(cmd_done), 32'd1);
        check("to err", 32'(err), 32'd1);
        tick();
        check("to cmd_ready", 32'(cmd_ready), 32'd1);
        check("to err sticky", 32'(err), 32'd1);
        check("to no enable", 32'({mem_w_enable, mem_r_enable}), 32'd0);
        mem_hang = 1'b0;
        rdata_ready = 1'b1;
        issue_cmd(1'b0, 32'h0000_0310, 16'd1);
        check("to err cleared", 32'(err), 32'd0);
        cnt = 0;
        while (!cmd_ready && cnt < 50) begin
            cnt++;
            tick();
        end
        check("to recover", 32'(cnt < 50), 32'd1);

        // Reset during the second request of a four-word read.
        d0 = done_cnt;
        issue_cmd(1'b0, 32'h0000_0400, 16'd4);
        cnt = 0;
        while (!(mem_r_enable && mem_addr == 32'h0000_0404) && cnt < 100) begin
            cnt++;
            tick();
        end
        check("mid wait word2", 32'(cnt < 100), 32'd1);
        reset = 1'b1;
        tick();
        check("mid cmd_ready", 32'(cmd_ready), 32'd1);
        check("mid enables", 32'({mem_w_enable, mem_r_enable}), 32'd0);
        check("mid cmd_done", 32'(cmd_done), 32'd0);
        check("mid err", 32'(err), 32'd0);
        check("mid rdata_valid", 32'(rdata_valid), 32'd0);
        check("mid wdata_ready", 32'(wdata_ready), 32'd0);
        check("mid mem_addr", mem_addr, 32'h0);
        check("mid mem_wdata", mem_wdata, 32'h0);
        check("mid rdata", rdata, 32'h0);
        reset = 1'b0;
        rdata_ready = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("mid no cmd_done", 32'(done_cnt - d0), 32'd0);
        run_burst(10, vecs[0]);

        check("protocol violations", 32'(viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
